// File: rtl/mips_mc_datapath_if.sv
// Control, status and memory-bus bundle between the multicycle MIPS controller
// (master) and the datapath (slave).
interface mips_mc_datapath_if;
  logic        memtoreg;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic        regdst;
  logic        regwrite;
  logic [2:0]  alucontrol;
  logic        iord;
  logic        irwrite;
  logic        pcen;
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  modport master (
    output memtoreg, alusrca, alusrcb, pcsrc, regdst, regwrite,
           alucontrol, iord, irwrite, pcen, readdata,
    input  adr, writedata, op, funct, zero
  );

  modport slave (
    input  memtoreg, alusrca, alusrcb, pcsrc, regdst, regwrite,
           alucontrol, iord, irwrite, pcen, readdata,
    output adr, writedata, op, funct, zero
  );
endinterface

// File: rtl/mips_mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file and ALU.
// Optional macro DATAPATH_DBG_EN adds an asynchronous register-file debug read port.
module mips_mc_datapath #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_datapath_if.slave    bus
`ifdef DATAPATH_DBG_EN
  ,
  input  logic [4:0]           dbg_addr,
  output logic [WIDTH-1:0]     dbg_data
`endif
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_sel_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_aluout;
  logic [WIDTH-1:0] r_rf [32];

  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] w_signimm;
  logic [WIDTH-1:0] w_srca;
  logic [WIDTH-1:0] w_srcb;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_pcnext;

  // Instruction field decode and register-file port selection.
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_waddr   = bus.regdst   ? r_ir[15:11] : w_rt;
  assign w_wdata   = bus.memtoreg ? r_mdr       : r_aluout;
  assign w_signimm = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};

  // r0 is hardwired to zero on every read port, independent of what it holds.
  assign w_rd1 = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? '0 : r_rf[w_rt];

  assign w_srca = bus.alusrca ? r_a : r_pc;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_srcb = r_b;
    case (srcb_sel_e'(bus.alusrcb))
      SRCB_REG:    w_srcb = r_b;
      SRCB_FOUR:   w_srcb = WIDTH'(4);
      SRCB_IMM:    w_srcb = w_signimm;
      SRCB_IMM_SH: w_srcb = {w_signimm[WIDTH-3:0], 2'b00};
      default:     w_srcb = r_b;
    endcase
  end

  // Encodings 011/100/101 are unused and produce zero.
  always_comb begin
    w_alu_result = '0;
    case (bus.alucontrol)
      ALU_ADD: w_alu_result = w_srca + w_srcb;
      ALU_SUB: w_alu_result = w_srca - w_srcb;
      ALU_AND: w_alu_result = w_srca & w_srcb;
      ALU_OR:  w_alu_result = w_srca | w_srcb;
      ALU_SLT: w_alu_result = ($signed(w_srca) < $signed(w_srcb)) ? WIDTH'(1) : '0;
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_pcnext = r_pc;
    case (pc_sel_e'(bus.pcsrc))
      PC_ALU:    w_pcnext = w_alu_result;
      PC_ALUOUT: w_pcnext = r_aluout;
      PC_JUMP:   w_pcnext = {r_pc[31:28], r_ir[25:0], 2'b00};
      PC_HOLD:   w_pcnext = r_pc;
      default:   w_pcnext = r_pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      r_mdr    <= bus.readdata;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
      if (bus.irwrite) r_ir <= bus.readdata;
      if (bus.pcen)    r_pc <= w_pcnext;
    end
  end

  // NOTE: the register file must clear on reset, so it is built from flops
  // rather than a RAM macro; the reset loop is intentional.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (bus.regwrite && (w_waddr != 5'd0)) begin
      r_rf[w_waddr] <= w_wdata;
    end
  end

  assign bus.adr       = bus.iord ? r_aluout : r_pc;
  assign bus.writedata = r_b;
  assign bus.op        = r_ir[31:26];
  assign bus.funct     = r_ir[5:0];
  assign bus.zero      = (w_alu_result == '0);

`ifdef DATAPATH_DBG_EN
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : r_rf[dbg_addr];
`endif

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Self-checking bench for mips_mc_datapath: an architectural model checked every
// cycle, plus directed literal checks from hand-computed instruction sequences.
module tb_mips_mc_datapath;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mips_mc_datapath_if bus ();

`ifdef DATAPATH_DBG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  mips_mc_datapath #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DATAPATH_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;

  function automatic logic [31:0] m_reg(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : m_rf[idx];
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] a, b, imm;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    a   = bus.alusrca ? m_a : m_pc;
    case (bus.alusrcb)
      2'b00:   b = m_b;
      2'b01:   b = 32'd4;
      2'b10:   b = imm;
      default: b = imm * 4;
    endcase
    case (bus.alucontrol)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_next_pc();
    case (bus.pcsrc)
      2'b00:   return m_alu();
      2'b01:   return m_aluout;
      2'b10:   return {m_pc[31:28], m_ir[25:0], 2'b00};
      default: return m_pc;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_valid  <= 1'b1;
      m_pc     <= 32'h0;
      m_ir     <= 32'h0;
      m_mdr    <= 32'h0;
      m_a      <= 32'h0;
      m_b      <= 32'h0;
      m_aluout <= 32'h0;
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
    end else if (m_valid) begin
      m_mdr    <= bus.readdata;
      m_a      <= m_reg(m_ir[25:21]);
      m_b      <= m_reg(m_ir[20:16]);
      m_aluout <= m_alu();
      if (bus.irwrite) m_ir <= bus.readdata;
      if (bus.pcen)    m_pc <= m_next_pc();
      if (bus.regwrite) begin
        if (bus.regdst) m_rf[m_ir[15:11]] <= bus.memtoreg ? m_mdr : m_aluout;
        else            m_rf[m_ir[20:16]] <= bus.memtoreg ? m_mdr : m_aluout;
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      check("adr",       bus.adr,                 bus.iord ? m_aluout : m_pc);
      check("writedata", bus.writedata,           m_b);
      check("op",        {26'd0, bus.op},         {26'd0, m_ir[31:26]});
      check("funct",     {26'd0, bus.funct},      {26'd0, m_ir[5:0]});
      check("zero",      {31'd0, bus.zero},       {31'd0, (m_alu() == 32'd0)});
`ifdef DATAPATH_DBG_EN
      check("dbg_data",  dbg_data,                m_reg(dbg_addr));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b11;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alucontrol = 3'b010;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
  endtask

  // Loads IR, then one more edge so A/B hold the new rs/rt values.
  task automatic load_ir(input logic [31:0] instr);
    idle();
    bus.readdata = instr;
    bus.irwrite  = 1'b1;
    tick();
    bus.irwrite  = 1'b0;
    tick();
  endtask

  // Writes a value into register r through MDR using an rt-addressed IR.
  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({6'd0, 5'd0, r, 16'd0});
    bus.readdata = v;
    tick();
    bus.memtoreg = 1'b1;
    bus.regdst   = 1'b0;
    bus.regwrite = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.readdata = 32'h0;
`ifdef DATAPATH_DBG_EN
    dbg_addr = 5'd0;
`endif
    idle();
    bus.pcen  = 1'b1;
    bus.pcsrc = 2'b00;
    tick();
    tick();
    #1;
    check("rst_adr",   bus.adr,            32'h0);
    check("rst_op",    {26'd0, bus.op},    32'h0);
    check("rst_funct", {26'd0, bus.funct}, 32'h0);
    check("rst_zero",  {31'd0, bus.zero},  32'h1);
    check("rst_wdata", bus.writedata,      32'h0);

    // Fetch addi $t0,$zero,5
    reset          = 1'b1;
    bus.readdata   = 32'h2008_0005;
    bus.irwrite    = 1'b1;
    bus.pcen       = 1'b1;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b01;
    bus.alucontrol = 3'b010;
    bus.pcsrc      = 2'b00;
    tick();
    idle();
    #1;
    check("fetch_op",    {26'd0, bus.op},    32'h0000_0008);
    check("fetch_funct", {26'd0, bus.funct}, 32'h0000_0005);
    check("fetch_pc",    bus.adr,            32'h0000_0004);

    // Execute: ALUOut = 0 + 5, then writeback to rt=8
    bus.alusrca = 1'b1;
    bus.alusrcb = 2'b10;
    tick();
    bus.iord = 1'b1;
    #1;
    check("exec_aluout", bus.adr, 32'h0000_0005);
    bus.iord     = 1'b0;
    bus.regwrite = 1'b1;
    tick();
    idle();

    // add $t0,$t0,$t0: A = B = rf[8] = 5, observe A+4 through ALUOut
    load_ir(32'h0108_4020);
    bus.alusrca = 1'b1;
    bus.alusrcb = 2'b01;
    tick();
    bus.iord = 1'b1;
    #1;
    check("rf8_via_a", bus.adr,       32'h0000_0009);
    check("rf8_via_b", bus.writedata, 32'h0000_0005);
    idle();

    // r0 write attempt with DEADBEEF
    load_ir(32'h0100_0000);
    bus.readdata = 32'hDEAD_BEEF;
    tick();
    bus.memtoreg = 1'b1;
    bus.regwrite = 1'b1;
    tick();
    idle();
    tick();
    #1;
    check("r0_still_zero", bus.writedata, 32'h0);
`ifdef DATAPATH_DBG_EN
    dbg_addr = 5'd0;
    #1;
    check("dbg_r0", dbg_data, 32'h0);
    dbg_addr = 5'd8;
    #1;
    check("dbg_r8", dbg_data, 32'h5);
`endif

    // beq-style compare
    set_reg(5'd10, 32'd3);
    set_reg(5'd9,  32'd7);
    load_ir(32'h0129_0000);
    bus.alusrca    = 1'b1;
    bus.alucontrol = 3'b110;
    #1;
    check("beq_equal", {31'd0, bus.zero}, 32'h1);
    load_ir(32'h012A_0000);
    bus.alusrca    = 1'b1;
    bus.alucontrol = 3'b110;
    #1;
    check("beq_differ", {31'd0, bus.zero}, 32'h0);

    // slt -1 < 1
    set_reg(5'd11, 32'hFFFF_FFFF);
    set_reg(5'd12, 32'd1);
    load_ir(32'h016C_0000);
    bus.alusrca    = 1'b1;
    bus.alucontrol = 3'b111;
    tick();
    bus.iord = 1'b1;
    #1;
    check("slt_signed", bus.adr, 32'h0000_0001);
    bus.iord  = 1'b0;
    bus.pcsrc = 2'b01;
    bus.pcen  = 1'b1;
    tick();
    idle();
    #1;
    check("pc_from_aluout", bus.adr, 32'h0000_0001);

    // Jump from PC = 1000_0008
    set_reg(5'd13, 32'h1000_0008);
    load_ir(32'h01A0_0000);
    bus.alusrca = 1'b1;
    bus.pcsrc   = 2'b00;
    bus.pcen    = 1'b1;
    tick();
    idle();
    #1;
    check("pc_from_alu", bus.adr, 32'h1000_0008);
    bus.pcen = 1'b1;
    tick();
    idle();
    #1;
    check("pc_hold", bus.adr, 32'h1000_0008);
    load_ir(32'h0800_0010);
    bus.pcsrc = 2'b10;
    bus.pcen  = 1'b1;
    tick();
    idle();
    #1;
    check("jump_pc", bus.adr,         32'h1000_0040);
    check("jump_op", {26'd0, bus.op}, 32'h0000_0002);

    // Jump with reset in the same cycle: reset wins
    bus.pcsrc    = 2'b10;
    bus.pcen     = 1'b1;
    bus.regwrite = 1'b1;
    reset        = 1'b0;
    tick();
    reset = 1'b1;
    idle();
    #1;
    check("reset_wins_pc", bus.adr,         32'h0);
    check("reset_wins_op", {26'd0, bus.op}, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
